msu_stream_ctrl: RTL and testbench

- Parametrised control and streaming wrapper for the modular squaring core.
- Deserialises an initial value from an AXI-stream of configurable width and loads it into an external squaring core.
- Iterates the core a runtime-programmable number of times, then serialises the result back out over AXI-stream.
- Successor to the fixed 32-bit, single-shot msu front end: adds width generality, a programmable iteration count and partial-beat keep handling.

---
 rtl/msu_stream_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_msu_stream_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_stream_ctrl.sv
// msu_stream_ctrl: AXI-stream front end for an external modular squaring core.
// Receives an initial value, runs it through the core a programmable number of
// times, then streams the result back out.
// Optional build macro MSU_ITER_HDR_EN: prefix the output packet with header
// beats carrying the completed iteration count.
module msu_stream_ctrl #(
   parameter int unsigned AXI_LEN   = 32,
   parameter int unsigned DAT_BITS  = 1024,
   parameter int unsigned ITER_BITS = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ap_start,
   input  logic [ITER_BITS-1:0]   num_iter,
   output logic                   ap_done,
   output logic                   start_xfer,
   output logic                   busy,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [AXI_LEN-1:0]     s_axis_tdata,
   input  logic [AXI_LEN/8-1:0]   s_axis_tkeep,
   input  logic                   s_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [AXI_LEN-1:0]     m_axis_tdata,
   output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   core_start,
   output logic [DAT_BITS-1:0]    core_sq_in,
   input  logic [DAT_BITS-1:0]    core_sq_out,
   input  logic                   core_valid
);

   localparam int unsigned BEATS       = (DAT_BITS + AXI_LEN - 1) / AXI_LEN;
   localparam int unsigned KEEP_W      = AXI_LEN / 8;
`ifdef MSU_ITER_HDR_EN
   localparam int unsigned HDR_BEATS   = (ITER_BITS + AXI_LEN - 1) / AXI_LEN;
`else
   localparam int unsigned HDR_BEATS   = 0;
`endif
   localparam int unsigned TOTAL_BEATS = BEATS + HDR_BEATS;
   localparam int unsigned PAD_BITS    = BEATS * AXI_LEN;
   localparam int unsigned KTAB_BITS   = TOTAL_BEATS * KEEP_W;
   localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OUT_W       = (TOTAL_BEATS > 1) ? $clog2(TOTAL_BEATS) : 1;

   // Per-output-beat byte enables: full, except the last header beat and the
   // last value beat, which only cover bytes holding real bits.
   function automatic logic [KTAB_BITS-1:0] keep_table();
      logic [KTAB_BITS-1:0] tab;
      int unsigned          bits;
      tab = '0;
      for (int unsigned b = 0; b < TOTAL_BEATS; b++) begin
         bits = AXI_LEN;
         if (b + 1 == HDR_BEATS)
            bits = ITER_BITS - (HDR_BEATS - 1) * AXI_LEN;
         if (b + 1 == TOTAL_BEATS)
            bits = DAT_BITS - (BEATS - 1) * AXI_LEN;
         for (int unsigned y = 0; y < KEEP_W; y++)
            if (y * 8 < bits)
               tab = tab | (KTAB_BITS'(1) << (b * KEEP_W + y));
      end
      return tab;
   endfunction

   localparam logic [TOTAL_BEATS-1:0][KEEP_W-1:0] KEEP_TAB = keep_table();

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DRAIN, S_SQ_START, S_SQ_WAIT, S_UNLOAD, S_DONE
   } state_t;

   state_t                             state, next_state, load_exit;
   logic [DAT_BITS-1:0]                value, value_d, core_sq_in_d;
   logic [BEAT_W-1:0]                  in_idx, in_idx_d;
   logic [OUT_W-1:0]                   out_idx, out_idx_d;
   logic [ITER_BITS-1:0]               iter_num, iter_num_d;
   logic [ITER_BITS-1:0]               iter_cnt, iter_cnt_d, iter_cnt_inc;
   logic [AXI_LEN-1:0]                 in_masked;
   logic [BEATS-1:0][AXI_LEN-1:0]      in_words;
   logic [TOTAL_BEATS-1:0][AXI_LEN-1:0] out_words;
   logic                               in_fire, out_fire;
   logic                               ap_done_d, start_xfer_d, busy_d, s_tready_d, core_start_d;
   logic                               m_tvalid_d, m_tlast_d;
   logic [AXI_LEN-1:0]                 m_tdata_d;
   logic [KEEP_W-1:0]                  m_tkeep_d;

   assign in_fire      = s_axis_tvalid & s_axis_tready;
   assign out_fire     = m_axis_tvalid & m_axis_tready;
   assign iter_cnt_inc = iter_cnt + ITER_BITS'(1);
   assign load_exit    = (iter_num == '0) ? S_UNLOAD : S_SQ_START;

   // Zero the bytes whose keep bit is clear.
   for (genvar y = 0; y < KEEP_W; y++) begin : g_mask
      assign in_masked[y*8 +: 8] = s_axis_tkeep[y] ? s_axis_tdata[y*8 +: 8] : 8'h00;
   end

   // Value register with the incoming beat merged in at the current beat slot.
   always_comb begin
      in_words         = PAD_BITS'(value);
      in_words[in_idx] = in_masked;
   end

   // Output packet image: optional header beats below the zero-padded value.
`ifdef MSU_ITER_HDR_EN
   assign out_words = {PAD_BITS'(value), (HDR_BEATS * AXI_LEN)'(iter_cnt)};
`else
   assign out_words = PAD_BITS'(value);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (ap_start) next_state = S_LOAD;
         S_LOAD: begin
            if (in_fire) begin
               if (s_axis_tlast)                       next_state = load_exit;
               else if (in_idx == BEAT_W'(BEATS - 1))  next_state = S_DRAIN;
            end
         end
         S_DRAIN:    if (in_fire && s_axis_tlast) next_state = load_exit;
         S_SQ_START: next_state = S_SQ_WAIT;
         S_SQ_WAIT: begin
            if (core_valid)
               next_state = (iter_cnt_inc == iter_num) ? S_UNLOAD : S_SQ_START;
         end
         S_UNLOAD:   if (out_fire && m_axis_tlast) next_state = S_DONE;
         S_DONE:     next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   // Output and datapath next values; every output is registered below.
   always_comb begin
      value_d      = value;
      in_idx_d     = in_idx;
      out_idx_d    = out_idx;
      iter_num_d   = iter_num;
      iter_cnt_d   = iter_cnt;
      core_sq_in_d = core_sq_in;
      m_tvalid_d   = m_axis_tvalid;
      m_tdata_d    = m_axis_tdata;
      m_tkeep_d    = m_axis_tkeep;
      m_tlast_d    = m_axis_tlast;
      s_tready_d   = (next_state == S_LOAD) || (next_state == S_DRAIN);
      busy_d       = (next_state != S_IDLE);
      ap_done_d    = (next_state == S_DONE);
      start_xfer_d = (next_state == S_UNLOAD) && (state != S_UNLOAD);
      core_start_d = (next_state == S_SQ_START);
      case (state)
         S_IDLE: begin
            if (ap_start) begin
               value_d    = '0;
               in_idx_d   = '0;
               iter_num_d = num_iter;
               iter_cnt_d = '0;
            end
         end
         S_LOAD: begin
            if (in_fire) begin
               value_d  = DAT_BITS'(in_words);
               in_idx_d = in_idx + BEAT_W'(1);
            end
         end
         S_SQ_WAIT: begin
            if (core_valid) begin
               value_d    = core_sq_out;
               iter_cnt_d = iter_cnt_inc;
            end
         end
         S_UNLOAD: begin
            if (!m_axis_tvalid || m_axis_tready) begin
               if (m_axis_tvalid && m_axis_tlast) begin
                  m_tvalid_d = 1'b0;
                  m_tdata_d  = '0;
                  m_tkeep_d  = '0;
                  m_tlast_d  = 1'b0;
               end else begin
                  m_tvalid_d = 1'b1;
                  m_tdata_d  = out_words[out_idx];
                  m_tkeep_d  = KEEP_TAB[out_idx];
                  m_tlast_d  = (out_idx == OUT_W'(TOTAL_BEATS - 1));
                  out_idx_d  = out_idx + OUT_W'(1);
               end
            end
         end
         default: ;
      endcase
      if (start_xfer_d)
         out_idx_d = '0;
      if (core_start_d)
         core_sq_in_d = value_d;
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         value         <= '0;
         in_idx        <= '0;
         out_idx       <= '0;
         iter_num      <= '0;
         iter_cnt      <= '0;
         core_sq_in    <= '0;
         core_start    <= 1'b0;
         ap_done       <= 1'b0;
         start_xfer    <= 1'b0;
         busy          <= 1'b0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         value         <= value_d;
         in_idx        <= in_idx_d;
         out_idx       <= out_idx_d;
         iter_num      <= iter_num_d;
         iter_cnt      <= iter_cnt_d;
         core_sq_in    <= core_sq_in_d;
         core_start    <= core_start_d;
         ap_done       <= ap_done_d;
         start_xfer    <= start_xfer_d;
         busy          <= busy_d;
         s_axis_tready <= s_tready_d;
         m_axis_tvalid <= m_tvalid_d;
         m_axis_tdata  <= m_tdata_d;
         m_axis_tkeep  <= m_tkeep_d;
         m_axis_tlast  <= m_tlast_d;
      end
   end

endmodule

// File: tb/tb_msu_stream_ctrl.sv
// Bench for msu_stream_ctrl: a 64-bit instance driven against a squaring-core
// model, plus a 48-bit instance exercising the partial last-beat keep.
module tb_msu_stream_ctrl;

   localparam int unsigned AXI_LEN   = 32;
   localparam int unsigned ITER_BITS = 64;
`ifdef MSU_ITER_HDR_EN
   localparam int HB = 2;
`else
   localparam int HB = 0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic        clk, reset;
   // 64-bit instance
   logic        ap_start, ap_done, start_xfer, busy;
   logic [63:0] num_iter;
   logic        s_tvalid, s_tready, s_tlast;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        m_tvalid, m_tready, m_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        core_start, core_valid;
   logic [63:0] core_sq_in, core_sq_out;
   // 48-bit instance
   logic        b_ap_start, b_ap_done, b_start_xfer, b_busy;
   logic [63:0] b_num_iter;
   logic        b_s_tvalid, b_s_tready, b_s_tlast;
   logic [31:0] b_s_tdata;
   logic [3:0]  b_s_tkeep;
   logic        b_m_tvalid, b_m_tready, b_m_tlast;
   logic [31:0] b_m_tdata;
   logic [3:0]  b_m_tkeep;
   logic        b_core_start;
   logic [47:0] b_core_sq_in;
   wire  [47:0] b_core_sq_out = '0;
   wire         b_core_valid  = 1'b0;

   int          n_err = 0;
   int          n_chk = 0;
   beat_t       exp_q[$];
   beat_t       exp_b[$];
   logic [31:0] in_d [0:3];
   logic [3:0]  in_k [0:3];
   int          in_n;
   bit          stall_en = 1'b0;
   int          n_core = 0, n_done = 0, n_xfer = 0, n_core_b = 0;
   logic [63:0] cap_x = '0;

   msu_stream_ctrl #(.AXI_LEN(AXI_LEN), .DAT_BITS(64), .ITER_BITS(ITER_BITS)) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .num_iter(num_iter),
      .ap_done(ap_done), .start_xfer(start_xfer), .busy(busy),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .core_start(core_start), .core_sq_in(core_sq_in),
      .core_sq_out(core_sq_out), .core_valid(core_valid)
   );

   msu_stream_ctrl #(.AXI_LEN(AXI_LEN), .DAT_BITS(48), .ITER_BITS(ITER_BITS)) dut48 (
      .clk(clk), .reset(reset), .ap_start(b_ap_start), .num_iter(b_num_iter),
      .ap_done(b_ap_done), .start_xfer(b_start_xfer), .busy(b_busy),
      .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
      .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast),
      .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
      .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
      .core_start(b_core_start), .core_sq_in(b_core_sq_in),
      .core_sq_out(b_core_sq_out), .core_valid(b_core_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] keep_mask(input logic [3:0] k);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++)
         if (k[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   // Squaring core model: result x*x mod 2^64 three cycles after core_start.
   initial begin
      int          cdelay;
      logic [63:0] cx;
      cdelay = 0;
      cx = '0;
      core_valid = 1'b0;
      core_sq_out = '0;
      forever begin
         @(negedge clk);
         core_valid = 1'b0;
         if (reset) begin
            cdelay = 0;
         end else begin
            if (cdelay != 0) begin
               cdelay--;
               if (cdelay == 0) begin
                  core_sq_out = cx * cx;
                  core_valid = 1'b1;
               end
            end
            if (core_start) begin
               cx = core_sq_in;
               cap_x = core_sq_in;
               cdelay = 3;
               n_core++;
            end
         end
      end
   end

   // Output monitor for the 64-bit instance: random backpressure, hold check, scoreboard pop.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      beat_t       e;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (ap_done) n_done++;
         if (start_xfer) n_xfer++;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check_val("hold_valid", 64'(m_tvalid), 64'd1);
               check_val("hold_data", 64'(m_tdata), 64'(prev_data));
               check_val("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            m_tready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  check_val("unexpected_beat", 64'(exp_q.size()), 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  check_val("out_data", 64'(m_tdata), 64'(e.data));
                  check_val("out_keep", 64'(m_tkeep), 64'(e.keep));
                  check_val("out_last", 64'(m_tlast), 64'(e.last));
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
         end
      end
   end

   // Output monitor for the 48-bit instance.
   initial begin
      beat_t e;
      b_m_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (b_core_start) n_core_b++;
         if (!reset && b_m_tvalid && b_m_tready) begin
            if (exp_b.size() == 0) begin
               check_val("b_unexpected_beat", 64'(exp_b.size()), 64'd1);
            end else begin
               e = exp_b.pop_front();
               check_val("b_out_data", 64'(b_m_tdata), 64'(e.data));
               check_val("b_out_keep", 64'(b_m_tkeep), 64'(e.keep));
               check_val("b_out_last", 64'(b_m_tlast), 64'(e.last));
            end
         end
      end
   end

   task automatic set_in2(input logic [31:0] d0, input logic [3:0] k0,
                          input logic [31:0] d1, input logic [3:0] k1);
      in_n = 2;
      in_d[0] = d0; in_k[0] = k0;
      in_d[1] = d1; in_k[1] = k1;
   endtask

   // Expected packet: header beats (if built), then the value after `iters` squarings.
   task automatic push_exp(input logic [63:0] iters);
      logic [63:0] v;
      beat_t       e;
      v = '0;
      for (int k = 0; k < in_n && k < 2; k++)
         v = v | (64'(in_d[k] & keep_mask(in_k[k])) << (32 * k));
      for (int i = 0; i < int'(iters); i++)
         v = v * v;
      for (int h = 0; h < HB; h++) begin
         e.data = 32'(iters >> (32 * h)); e.keep = 4'hF; e.last = 1'b0;
         exp_q.push_back(e);
      end
      e.data = v[31:0];  e.keep = 4'hF; e.last = 1'b0; exp_q.push_back(e);
      e.data = v[63:32]; e.keep = 4'hF; e.last = 1'b1; exp_q.push_back(e);
   endtask

   task automatic send_a();
      bit ok;
      int t;
      for (int k = 0; k < in_n; k++) begin
         s_tvalid = 1'b1;
         s_tdata  = in_d[k];
         s_tkeep  = in_k[k];
         s_tlast  = (k == in_n - 1);
         t = 0;
         do begin
            ok = s_tready;
            @(negedge clk);
            t++;
         end while (!ok && t < 100);
         check_val("in_accept", 64'(ok), 64'd1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic start_a(input logic [63:0] iters);
      ap_start = 1'b1;
      num_iter = iters;
      @(negedge clk);
      ap_start = 1'b0;
      check_val("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic run_a(input string name, input logic [63:0] iters);
      int c0, d0, x0, t;
      c0 = n_core; d0 = n_done; x0 = n_xfer;
      push_exp(iters);
      start_a(iters);
      send_a();
      t = 0;
      while (!ap_done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check_val({name, "_done_seen"}, 64'(ap_done), 64'd1);
      @(negedge clk);
      check_val({name, "_done_pulse"}, 64'(ap_done), 64'd0);
      check_val({name, "_idle"}, 64'(busy), 64'd0);
      check_val({name, "_all_beats"}, 64'(exp_q.size()), 64'd0);
      check_val({name, "_done_cnt"}, 64'(n_done - d0), 64'd1);
      check_val({name, "_xfer_cnt"}, 64'(n_xfer - x0), 64'd1);
      check_val({name, "_core_starts"}, 64'(n_core - c0), iters);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      check_val({name, "_ap_done"}, 64'(ap_done), 64'd0);
      check_val({name, "_start_xfer"}, 64'(start_xfer), 64'd0);
      check_val({name, "_busy"}, 64'(busy), 64'd0);
      check_val({name, "_s_tready"}, 64'(s_tready), 64'd0);
      check_val({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
      check_val({name, "_m_tdata"}, 64'(m_tdata), 64'd0);
      check_val({name, "_m_tkeep"}, 64'(m_tkeep), 64'd0);
      check_val({name, "_m_tlast"}, 64'(m_tlast), 64'd0);
      check_val({name, "_core_start"}, 64'(core_start), 64'd0);
      check_val({name, "_core_sq_in"}, core_sq_in, 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    t, d0;
      beat_t e;
      reset = 1'b1;
      ap_start = 1'b0; num_iter = '0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      b_ap_start = 1'b0; b_num_iter = '0;
      b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;
      @(negedge clk);
      check_val("idle_busy", 64'(busy), 64'd0);
      check_val("idle_b_busy", 64'(b_busy), 64'd0);

      set_in2(32'h0000_0002, 4'hF, 32'h0000_0000, 4'hF);
      run_a("basic", 64'd5);
      run_a("wrap", 64'd6);
      set_in2(32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 4'hF);
      run_a("zero_iter", 64'd0);

      in_n = 1; in_d[0] = 32'h3; in_k[0] = 4'hF;
      run_a("short", 64'd1);
      check_val("short_sq_in", cap_x, 64'd3);

      in_n = 3;
      in_d[0] = 32'h1111_1111; in_k[0] = 4'hF;
      in_d[1] = 32'h2222_2222; in_k[1] = 4'hF;
      in_d[2] = 32'h3333_3333; in_k[2] = 4'hF;
      run_a("long", 64'd0);

      set_in2(32'hAABB_CCDD, 4'b0101, 32'h1234_5678, 4'b1000);
      run_a("keep", 64'd0);

      stall_en = 1'b1;
      set_in2(32'h0000_0002, 4'hF, 32'h0000_0000, 4'hF);
      run_a("stall", 64'd5);
      set_in2(32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 4'hF);
      run_a("stall_echo", 64'd0);
      stall_en = 1'b0;

      // Abort while the core is busy; no packet or ap_done may follow.
      d0 = n_done;
      set_in2(32'h0000_0002, 4'hF, 32'h0000_0000, 4'hF);
      start_a(64'd5);
      send_a();
      t = 0;
      while (!core_start && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_val("abort_reach_sq", 64'(core_start), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("abort");
      repeat (10) @(negedge clk);
      check_val("abort_no_done", 64'(n_done - d0), 64'd0);
      run_a("post_reset", 64'd5);

      // 48-bit value: last beat only carries two bytes.
      for (int h = 0; h < HB; h++) begin
         e.data = '0; e.keep = 4'hF; e.last = 1'b0; exp_b.push_back(e);
      end
      e.data = 32'hDEAD_BEEF; e.keep = 4'hF;    e.last = 1'b0; exp_b.push_back(e);
      e.data = 32'h0000_5678; e.keep = 4'b0011; e.last = 1'b1; exp_b.push_back(e);
      b_ap_start = 1'b1;
      b_num_iter = '0;
      @(negedge clk);
      b_ap_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bit ok;
         b_s_tvalid = 1'b1;
         b_s_tdata  = (k == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
         b_s_tkeep  = 4'hF;
         b_s_tlast  = (k == 1);
         t = 0;
         do begin
            ok = b_s_tready;
            @(negedge clk);
            t++;
         end while (!ok && t < 100);
         check_val("b_in_accept", 64'(ok), 64'd1);
      end
      b_s_tvalid = 1'b0;
      b_s_tlast  = 1'b0;
      t = 0;
      while (!b_ap_done && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check_val("b_done_seen", 64'(b_ap_done), 64'd1);
      @(negedge clk);
      check_val("b_all_beats", 64'(exp_b.size()), 64'd0);
      check_val("b_no_core", 64'(n_core_b), 64'd0);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
